jtag_scan_master: RTL
=====================

Name: jtag_scan_master

Overview:
- System-clock-domain JTAG initiator that drives TCK/TMS/TDI into a TAP exposing a 2-bit IR and 38-bit DR (the Nios II debug-slave scan chain).
- Each accepted command performs one IR scan followed by one DR scan, and returns the captured IR-out and DR bits.
- Used for in-fabric debug-port exercising and for bench stimulus of the debug slave.

Parameters:
- IR_WIDTH, 2, instruction register length.
- DR_WIDTH, 38, data register length.
- CLK_DIV, 2, clk cycles per TCK half-period; legal range >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master idle in Run-Test/Idle; command accepted when cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value to shift, LSB first.
- cmd_dr  in  DR_WIDTH  DR value to shift, LSB first.
- cmd_tlr  in  1  when set, perform a TAP reset sequence instead of a scan.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_ir  out  IR_WIDTH  bits captured during Shift-IR.
- rsp_dr  out  DR_WIDTH  bits captured during Shift-DR.
- busy  out  1  equals !cmd_ready.
- tck  out  1  JTAG clock; idles low.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data out.
- tdo  in  1  JTAG data in.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_ir=0, rsp_dr=0. TAP tracker state is TLR.
- Reset is asynchronous. Assertion mid-scan aborts the scan immediately: no rsp_valid, and outputs return to their reset values.
- After reset deasserts, the master runs the TLR sequence automatically: TMS=1 for 5 TCKs, then TMS=0 for 1 TCK, reaching RTI. cmd_ready rises the clk after the last TCK falling edge.
- TCK generation:
  - A divider toggles tck every CLK_DIV clks, only while busy.
  - tms/tdi change only on the clk that drives tck 1->0. The first bit is presented on the clk after acceptance.
  - tdo is registered on the clk that drives tck 0->1.
  - After the final falling edge, tck stays low.
- Scan sequence (TMS per TCK, starting from RTI):
  - 1,1,0,0 takes the TAP through SelDR, SelIR, CapIR to ShiftIR.
  - IR_WIDTH shift TCKs; TMS=0 except the last, which is 1 (Exit1-IR).
  - 1,1,0,0 takes the TAP through UpdIR, SelDR, CapDR to ShiftDR.
  - DR_WIDTH shift TCKs; last TMS=1 (Exit1-DR).
  - 1,0 takes the TAP through UpdDR to RTI.
  - Total is 10+IR_WIDTH+DR_WIDTH TCKs (50 at defaults, i.e. 200 clks at CLK_DIV=2).
- tdi outside shift states is 0.
- Shift order: bit 0 is driven first. The captured tdo stream shifts in from the MSB, so the first sampled bit lands at bit 0 after the full shift.
- cmd_tlr=1 runs the 6-TCK TLR sequence; rsp_valid pulses, and rsp_ir/rsp_dr hold their previous values.
- Completion: rsp_valid pulses on the same clk that cmd_ready rises. rsp_ir/rsp_dr update that clk and hold until the next completion.
- rsp has no backpressure.
- cmd_valid while busy is ignored. Command fields are sampled only at acceptance.
- FSM states: TLR_SEQ, IDLE, PRE_IR, SHIFT_IR, MID, SHIFT_DR, POST, DONE.
  - A bit counter sized for max(IR_WIDTH, DR_WIDTH) counts TCKs within each state.
  - A TAP-state tracker (16-state IEEE 1149.1 encoding) is kept for debug and assertions.

Decomposition:
- Package jtag_pkg holds:
  - the 16-value TAP state enum,
  - the master FSM enum,
  - constants TLR_TCKS=5, PRE_TCKS=4, MID_TCKS=4, POST_TCKS=2,
  - a next-TAP-state function (state, tms).
- One sub-module, jtag_tck_gen, provides:
  - CLK_DIV divider, enable, and tck register,
  - rise_stb/fall_stb single-clk strobes.

Test Plan:
- Reset release, CLK_DIV=2: 6 tck pulses with tms=1,1,1,1,1,0, then cmd_ready=1. The tracker reports RTI.
- Loopback tdo=tdi, cmd_ir=2'b10, cmd_dr=38'h2A_5A5A_5A5A:
  - 50 tck pulses, 200 clks;
  - rsp_ir=2'b10, rsp_dr=38'h2A_5A5A_5A5A;
  - rsp_valid a single cycle.
- 1-bit bypass TAP model (tdo = registered tdi), cmd_dr=38'h00_0000_0001: rsp_dr=38'h00_0000_0002, with captured bit 0 = bypass reset value 0.
- Back-to-back: cmd_valid held high with two commands. The second is accepted on the rsp_valid cycle, tck stays low ≥ 1 clk between scans, and both responses are correct.
- Reset asserted at TCK 20 of a scan: tck=0, tms=1, cmd_ready=0 immediately, and no rsp_valid. After release, the TLR sequence repeats.
- cmd_tlr=1 from idle: 6 TCKs, rsp_valid pulse, rsp_dr unchanged; cmd_valid asserted during busy has no effect.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG scan master.
//   tap_state_t    : 16-state IEEE 1149.1 TAP controller encoding
//   master_state_t : scan master sequencing states
//   *_TCKS         : fixed TMS sequence lengths
//   tap_next()     : TAP state transition on a TCK rising edge
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_t;

  typedef enum logic [2:0] {
    TLR_SEQ,
    IDLE,
    PRE_IR,
    SHIFT_IR,
    MID,
    SHIFT_DR,
    POST,
    DONE
  } master_state_t;

  localparam int unsigned TLR_TCKS  = 5;
  localparam int unsigned PRE_TCKS  = 4;
  localparam int unsigned MID_TCKS  = 4;
  localparam int unsigned POST_TCKS = 2;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = s;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_scan_master_tck_gen.sv
// TCK generator: toggles tck every CLK_DIV clk cycles while en is high,
// otherwise holds tck low and the divider cleared.
//   clk, rst  : system clock, async active-high reset
//   en        : run the divider
//   tck       : JTAG clock (idles low)
//   rise_stb  : high on the clk whose edge drives tck 0->1
//   fall_stb  : high on the clk whose edge drives tck 1->0
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt;
  logic          hit;

  assign hit      = en && (div_cnt == CW'(CLK_DIV - 1));
  assign rise_stb = hit && !tck;
  assign fall_stb = hit && tck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (hit) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG initiator: per command, one IR scan then one DR scan from
// Run-Test/Idle back to Run-Test/Idle, or a TAP reset sequence.
//   clk, reset         : system clock, async active-high reset
//   cmd_valid/ready    : command handshake (ready only in Run-Test/Idle)
//   cmd_ir, cmd_dr     : values shifted LSB first
//   cmd_tlr            : run TAP reset sequence instead of a scan
//   rsp_valid          : one-cycle completion pulse
//   rsp_ir, rsp_dr     : captured tdo, held until next scan completion
//   busy               : !cmd_ready
//   tck, tms, tdi, tdo : JTAG pins
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_tlr,
  output logic                rsp_valid,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  localparam int unsigned MAX_SD  = (IR_WIDTH > DR_WIDTH) ? IR_WIDTH : DR_WIDTH;
  localparam int unsigned MAX_LEN = (MAX_SD > TLR_TCKS + 1) ? MAX_SD : TLR_TCKS + 1;
  localparam int          CNT_W   = $clog2(MAX_LEN);

  master_state_t       state, state_n, pres_state;
  logic [CNT_W-1:0]    cnt, cnt_n;
  int unsigned         pres_idx;
  logic                tms_n, tdi_n;
  logic [IR_WIDTH-1:0] ir_sh, ir_sh_n, cap_ir, cap_ir_n, rsp_ir_n;
  logic [DR_WIDTH-1:0] dr_sh, dr_sh_n, cap_dr, cap_dr_n, rsp_dr_n;
  logic                rsp_valid_n;
  logic                pend, pend_n, tlr_op, tlr_op_n;
  logic                tck_en, rise_stb, fall_stb;
  tap_state_t          tap_state;

  function automatic int unsigned phase_len(input master_state_t s);
    int unsigned l;
    case (s)
      TLR_SEQ:  l = TLR_TCKS + 1;
      PRE_IR:   l = PRE_TCKS;
      SHIFT_IR: l = IR_WIDTH;
      MID:      l = MID_TCKS;
      SHIFT_DR: l = DR_WIDTH;
      POST:     l = POST_TCKS;
      default:  l = 1;
    endcase
    return l;
  endfunction

  // TMS for TCK number idx within a phase.
  function automatic logic phase_tms(input master_state_t s, input int unsigned idx);
    logic t;
    case (s)
      TLR_SEQ:     t = (idx < TLR_TCKS);
      PRE_IR, MID: t = (idx < 2);
      SHIFT_IR:    t = (idx == IR_WIDTH - 1);
      SHIFT_DR:    t = (idx == DR_WIDTH - 1);
      POST:        t = (idx == 0);
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic master_state_t phase_next(input master_state_t s);
    master_state_t n;
    case (s)
      PRE_IR:   n = SHIFT_IR;
      SHIFT_IR: n = MID;
      MID:      n = SHIFT_DR;
      SHIFT_DR: n = POST;
      default:  n = DONE;
    endcase
    return n;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign tck_en    = (state != IDLE) && (state != DONE);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (reset),
    .en       (tck_en),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // 'state' names the phase of the TCK whose tms/tdi are currently
  // presented; each falling edge presents the following TCK's bits.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tms_n       = tms;
    tdi_n       = tdi;
    ir_sh_n     = ir_sh;
    dr_sh_n     = dr_sh;
    cap_ir_n    = cap_ir;
    cap_dr_n    = cap_dr;
    rsp_ir_n    = rsp_ir;
    rsp_dr_n    = rsp_dr;
    rsp_valid_n = 1'b0;
    pend_n      = pend;
    tlr_op_n    = tlr_op;
    pres_state  = state;
    pres_idx    = 0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n  = cmd_tlr ? TLR_SEQ : PRE_IR;
          cnt_n    = '0;
          tms_n    = 1'b1;
          tdi_n    = 1'b0;
          ir_sh_n  = cmd_ir;
          dr_sh_n  = cmd_dr;
          pend_n   = 1'b1;
          tlr_op_n = cmd_tlr;
        end
      end
      DONE: begin
        state_n     = IDLE;
        rsp_valid_n = pend;
        pend_n      = 1'b0;
        if (pend && !tlr_op) begin
          rsp_ir_n = cap_ir;
          rsp_dr_n = cap_dr;
        end
      end
      default: begin
        if (rise_stb) begin
          if (state == SHIFT_IR) cap_ir_n = {tdo, cap_ir[IR_WIDTH-1:1]};
          if (state == SHIFT_DR) cap_dr_n = {tdo, cap_dr[DR_WIDTH-1:1]};
        end
        if (fall_stb) begin
          if (cnt == CNT_W'(phase_len(state) - 1)) begin
            pres_state = phase_next(state);
            pres_idx   = 0;
          end else begin
            pres_state = state;
            pres_idx   = 32'(cnt) + 1;
          end
          state_n = pres_state;
          cnt_n   = CNT_W'(pres_idx);
          tdi_n   = 1'b0;
          // Entering DONE keeps the final tms=0 so the TAP idles in RTI.
          if (pres_state != DONE) tms_n = phase_tms(pres_state, pres_idx);
          if (pres_state == SHIFT_IR) begin
            tdi_n   = ir_sh[0];
            ir_sh_n = ir_sh >> 1;
          end
          if (pres_state == SHIFT_DR) begin
            tdi_n   = dr_sh[0];
            dr_sh_n = dr_sh >> 1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TLR_SEQ;
      cnt       <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      ir_sh     <= '0;
      dr_sh     <= '0;
      cap_ir    <= '0;
      cap_dr    <= '0;
      rsp_ir    <= '0;
      rsp_dr    <= '0;
      rsp_valid <= 1'b0;
      pend      <= 1'b0;
      tlr_op    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tms       <= tms_n;
      tdi       <= tdi_n;
      ir_sh     <= ir_sh_n;
      dr_sh     <= dr_sh_n;
      cap_ir    <= cap_ir_n;
      cap_dr    <= cap_dr_n;
      rsp_ir    <= rsp_ir_n;
      rsp_dr    <= rsp_dr_n;
      rsp_valid <= rsp_valid_n;
      pend      <= pend_n;
      tlr_op    <= tlr_op_n;
    end
  end

  // Mirror of the target TAP controller, advanced on each TCK rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_state <= TAP_TLR;
    end else if (rise_stb) begin
      tap_state <= tap_next(tap_state, tms);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == IDLE) assert (tap_state == TAP_RTI);
  end

endmodule
